// File: rtl/pkt_mem_arbiter.sv
// pkt_mem_arbiter: round-robin, packet-locked arbiter feeding a registered packet-memory write port.
// Optional stall watchdog compiled in with PKT_ARB_WATCHDOG_EN.
module pkt_mem_arbiter #(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 32,
    parameter int WDOG_CYCLES = 64
) (
    input  logic                         CLK,
    input  logic                         reset,
    input  logic [NUM_REQ-1:0]           req_valid_i,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data_i,
    input  logic [NUM_REQ-1:0]           req_last_i,
    output logic [NUM_REQ-1:0]           req_ready_o,
    output logic [DATA_W-1:0]            mem_out,
    output logic                         mem_w_valid,
    input  logic                         w_ready,
    output logic                         mem_w_last,
    output logic [$clog2(NUM_REQ)-1:0]   grant_o,
    output logic                         busy_o,
    output logic                         abort_o
);
    localparam int GW = $clog2(NUM_REQ);
    localparam int IW = GW + 1;
    localparam logic [GW:0] NR = IW'(NUM_REQ);
    typedef enum logic {IDLE, LOCK} state_t;
    state_t state;
    logic [GW-1:0] rr_ptr, sel, nxt;
    logic [GW:0] idx;
    logic rdy, own_v, take, wdog_hit;
    // scan downward so the lowest offset from rr_ptr wins
    always_comb begin
        sel = rr_ptr;
        idx = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            idx = {1'b0, rr_ptr} + IW'(k);
            idx = (idx >= NR) ? idx - NR : idx;
            sel = req_valid_i[idx[GW-1:0]] ? idx[GW-1:0] : sel;
        end
    end
    assign nxt         = (grant_o == GW'(NUM_REQ - 1)) ? '0 : grant_o + 1'b1;
    assign rdy         = !mem_w_valid || w_ready;
    assign own_v       = req_valid_i[grant_o];
    assign busy_o      = state == LOCK;
    assign take        = busy_o && own_v && rdy;
    assign req_ready_o = (busy_o && rdy) ? NUM_REQ'(1) << grant_o : '0;
`ifdef PKT_ARB_WATCHDOG_EN
    localparam logic [7:0] WDOG_LIM = 8'(WDOG_CYCLES - 1);
    logic [7:0] wdog;
    assign wdog_hit = busy_o && !own_v && (wdog == WDOG_LIM);
`else
    assign wdog_hit = 1'b0;
    assign abort_o  = 1'b0;
`endif
    always_ff @(posedge CLK or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            rr_ptr      <= '0;
            grant_o     <= '0;
            mem_out     <= '0;
            mem_w_valid <= 1'b0;
            mem_w_last  <= 1'b0;
`ifdef PKT_ARB_WATCHDOG_EN
            wdog        <= '0;
            abort_o     <= 1'b0;
`endif
        end else begin
            if (take) begin
                mem_out     <= req_data_i[int'(grant_o) * DATA_W +: DATA_W];
                mem_w_last  <= req_last_i[grant_o];
                mem_w_valid <= 1'b1;
            end else if (w_ready) begin
                mem_w_valid <= 1'b0;
            end
            if (state == IDLE && |req_valid_i) begin
                grant_o <= sel;
                state   <= LOCK;
            end else if ((take && req_last_i[grant_o]) || wdog_hit) begin
                rr_ptr <= nxt;
                state  <= IDLE;
            end
`ifdef PKT_ARB_WATCHDOG_EN
            abort_o <= wdog_hit;
            wdog    <= (busy_o && !own_v && !wdog_hit) ? wdog + 1'b1 : '0;
`endif
        end
    end
endmodule

// File: tb/tb_pkt_mem_arbiter.sv
// tb_pkt_mem_arbiter: queue-driven requester models plus a scoreboard on the memory write port.
module tb_pkt_mem_arbiter;
    localparam int NR = 4;
    localparam int DW = 32;
    logic CLK = 1'b0;
    logic reset = 1'b1;
    logic [NR-1:0] req_valid_i = '0;
    logic [NR-1:0] req_last_i = '0;
    logic [NR*DW-1:0] req_data_i = '0;
    logic [NR-1:0] req_ready_o;
    logic [DW-1:0] mem_out;
    logic mem_w_valid, mem_w_last, busy_o, abort_o;
    logic w_ready = 1'b1;
    logic [1:0] grant_o;
    int errors = 0;
    int checks = 0;
    logic [32:0] exp_q[$];
    logic [31:0] src_d[NR][32];
    logic src_l[NR][32];
    int hd[NR] = '{default: 0};
    int tl[NR] = '{default: 0};
    int nruns;
    int run_g[8], run_len[8], gap[8];
    logic hs;
    logic [32:0] hv, he;

    pkt_mem_arbiter #(.NUM_REQ(NR), .DATA_W(DW), .WDOG_CYCLES(8)) dut (
        .CLK(CLK), .reset(reset), .req_valid_i(req_valid_i), .req_data_i(req_data_i),
        .req_last_i(req_last_i), .req_ready_o(req_ready_o), .mem_out(mem_out),
        .mem_w_valid(mem_w_valid), .w_ready(w_ready), .mem_w_last(mem_w_last),
        .grant_o(grant_o), .busy_o(busy_o), .abort_o(abort_o)
    );

    always #5 CLK = ~CLK;

    // requester models: present queue heads, pop on an accepted beat
    initial begin : drv
        logic [NR-1:0] tk;
        forever begin
            @(negedge CLK);
            tk = req_valid_i & req_ready_o;
            @(posedge CLK);
            #1;
            for (int i = 0; i < NR; i++) begin
                if (tk[i] && !reset) hd[i]++;
                if (hd[i] != tl[i]) begin
                    req_valid_i[i] = 1'b1;
                    req_data_i[i*DW +: DW] = src_d[i][hd[i] % 32];
                    req_last_i[i] = src_l[i][hd[i] % 32];
                end else begin
                    req_valid_i[i] = 1'b0;
                    req_last_i[i] = 1'b0;
                end
            end
        end
    end

    always @(negedge CLK) begin
        hs = !reset && mem_w_valid && w_ready;
        hv = {mem_w_last, mem_out};
    end

    always @(posedge CLK) begin
        if (hs && !reset) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL mem_beat unexpected got=%h", hv);
            end else begin
                he = exp_q.pop_front();
                if (hv !== he) begin
                    errors++;
                    $display("FAIL mem_beat got=%h want=%h", hv, he);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL timeout");
        $fatal(1, "timeout");
    end

    task automatic push(input int r, input logic [31:0] d, input logic l);
        src_d[r][tl[r] % 32] = d;
        src_l[r][tl[r] % 32] = l;
        tl[r]++;
    endtask

    task automatic expect_beat(input logic [31:0] d, input logic l);
        exp_q.push_back({l, d});
    endtask

    task automatic flush();
        for (int i = 0; i < NR; i++) hd[i] = tl[i];
    endtask

    task automatic run_trace(input int n);
        int idle;
        logic prev;
        idle = 0;
        prev = 1'b0;
        nruns = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge CLK);
            if (busy_o) begin
                if (!prev && nruns < 8) begin
                    run_g[nruns] = int'(grant_o);
                    run_len[nruns] = 1;
                    gap[nruns] = idle;
                    nruns++;
                end else if (prev) begin
                    run_len[nruns-1]++;
                end
                idle = 0;
            end else begin
                idle++;
            end
            prev = busy_o;
        end
    endtask

    task automatic test_reset();
        repeat (2) @(negedge CLK);
        checks += 7;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL rst_busy got=%b want=0", busy_o); end
        if (grant_o !== 2'd0) begin errors++; $display("FAIL rst_grant got=%0d want=0", grant_o); end
        if (req_ready_o !== 4'h0) begin errors++; $display("FAIL rst_ready got=%h want=0", req_ready_o); end
        if (mem_out !== 32'h0) begin errors++; $display("FAIL rst_mem_out got=%h want=0", mem_out); end
        if (mem_w_valid !== 1'b0) begin errors++; $display("FAIL rst_w_valid got=%b want=0", mem_w_valid); end
        if (mem_w_last !== 1'b0) begin errors++; $display("FAIL rst_w_last got=%b want=0", mem_w_last); end
        if (abort_o !== 1'b0) begin errors++; $display("FAIL rst_abort got=%b want=0", abort_o); end
        reset = 1'b0;
        repeat (2) @(negedge CLK);
    endtask

    task automatic test_two_packets();
        for (int b = 0; b < 3; b++) begin
            push(0, 32'hA000_0000 + b, b == 2);
            push(2, 32'hC000_0000 + b, b == 2);
        end
        for (int b = 0; b < 3; b++) expect_beat(32'hA000_0000 + b, b == 2);
        for (int b = 0; b < 3; b++) expect_beat(32'hC000_0000 + b, b == 2);
        run_trace(14);
        checks += 6;
        if (nruns !== 2) begin errors++; $display("FAIL two_pkt_runs got=%0d want=2", nruns); end
        if (run_g[0] !== 0 || run_len[0] !== 3) begin errors++; $display("FAIL two_pkt_first got=g%0d/len%0d want=g0/len3", run_g[0], run_len[0]); end
        if (gap[1] !== 1) begin errors++; $display("FAIL two_pkt_gap got=%0d want=1", gap[1]); end
        if (run_g[1] !== 2) begin errors++; $display("FAIL two_pkt_second_grant got=%0d want=2", run_g[1]); end
        if (run_len[1] !== 3) begin errors++; $display("FAIL two_pkt_second_len got=%0d want=3", run_len[1]); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL two_pkt_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_rr_ptr();
        push(0, 32'h0000_0010, 1'b1);
        push(3, 32'h0000_0030, 1'b1);
        expect_beat(32'h0000_0030, 1'b1);
        expect_beat(32'h0000_0010, 1'b1);
        run_trace(10);
        checks += 3;
        if (nruns !== 2) begin errors++; $display("FAIL rr_runs got=%0d want=2", nruns); end
        if (run_g[0] !== 3) begin errors++; $display("FAIL rr_first got=%0d want=3", run_g[0]); end
        if (run_g[1] !== 0) begin errors++; $display("FAIL rr_second got=%0d want=0", run_g[1]); end
    endtask

    task automatic test_stall();
        int c;
        @(posedge CLK);
        #1 w_ready = 1'b0;
        @(negedge CLK);
        push(1, 32'hDEAD_BEEF, 1'b0);
        push(1, 32'h1111_1111, 1'b1);
        expect_beat(32'hDEAD_BEEF, 1'b0);
        expect_beat(32'h1111_1111, 1'b1);
        c = 0;
        while (!mem_w_valid && c < 20) begin @(negedge CLK); c++; end
        checks++;
        if (mem_w_valid !== 1'b1) begin errors++; $display("FAIL stall_first_beat got=%b want=1", mem_w_valid); end
        for (int i = 0; i < 5; i++) begin
            checks += 3;
            if (mem_out !== 32'hDEAD_BEEF) begin errors++; $display("FAIL stall_hold_data got=%h want=deadbeef", mem_out); end
            if (mem_w_valid !== 1'b1) begin errors++; $display("FAIL stall_hold_valid got=%b want=1", mem_w_valid); end
            if (req_ready_o[1] !== 1'b0) begin errors++; $display("FAIL stall_ready got=%b want=0", req_ready_o[1]); end
            @(negedge CLK);
        end
        @(posedge CLK);
        #1 w_ready = 1'b1;
        repeat (6) @(negedge CLK);
        checks++;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL stall_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_round_robin();
        @(negedge CLK) reset = 1'b1;
        @(negedge CLK) reset = 1'b0;
        push(0, 32'h0000_0100, 1'b1);
        push(0, 32'h0000_0101, 1'b1);
        push(1, 32'h0000_0110, 1'b1);
        push(2, 32'h0000_0120, 1'b1);
        push(3, 32'h0000_0130, 1'b1);
        expect_beat(32'h0000_0100, 1'b1);
        expect_beat(32'h0000_0110, 1'b1);
        expect_beat(32'h0000_0120, 1'b1);
        expect_beat(32'h0000_0130, 1'b1);
        expect_beat(32'h0000_0101, 1'b1);
        run_trace(16);
        checks++;
        if (nruns !== 5) begin errors++; $display("FAIL rr4_runs got=%0d want=5", nruns); end
        for (int r = 0; r < 5; r++) begin
            checks += 2;
            if (run_g[r] !== r % 4) begin errors++; $display("FAIL rr4_grant%0d got=%0d want=%0d", r, run_g[r], r % 4); end
            if (run_len[r] !== 1) begin errors++; $display("FAIL rr4_len%0d got=%0d want=1", r, run_len[r]); end
        end
    endtask

    task automatic test_reset_mid_packet();
        int c;
        for (int b = 0; b < 4; b++) push(1, 32'hB100_0001 + b, b == 3);
        expect_beat(32'hB100_0001, 1'b0);
        c = 0;
        while (!(mem_w_valid && mem_out == 32'hB100_0002) && c < 20) begin @(negedge CLK); c++; end
        checks++;
        if (mem_out !== 32'hB100_0002) begin errors++; $display("FAIL mid_beat2 got=%h want=b1000002", mem_out); end
        #1 reset = 1'b1;
        #1;
        checks += 5;
        if (busy_o !== 1'b0) begin errors++; $display("FAIL mid_rst_busy got=%b want=0", busy_o); end
        if (grant_o !== 2'd0) begin errors++; $display("FAIL mid_rst_grant got=%0d want=0", grant_o); end
        if (req_ready_o !== 4'h0) begin errors++; $display("FAIL mid_rst_ready got=%h want=0", req_ready_o); end
        if (mem_out !== 32'h0 || mem_w_valid !== 1'b0) begin errors++; $display("FAIL mid_rst_mem got=%h/%b want=0/0", mem_out, mem_w_valid); end
        if (mem_w_last !== 1'b0) begin errors++; $display("FAIL mid_rst_last got=%b want=0", mem_w_last); end
        @(posedge CLK);
        #2 flush();
        repeat (2) @(negedge CLK);
        reset = 1'b0;
        push(3, 32'h0000_0033, 1'b1);
        push(1, 32'h0000_0011, 1'b1);
        expect_beat(32'h0000_0011, 1'b1);
        expect_beat(32'h0000_0033, 1'b1);
        run_trace(10);
        checks += 3;
        if (run_g[0] !== 1) begin errors++; $display("FAIL mid_restart_first got=%0d want=1", run_g[0]); end
        if (run_g[1] !== 3) begin errors++; $display("FAIL mid_restart_second got=%0d want=3", run_g[1]); end
        if (exp_q.size() !== 0) begin errors++; $display("FAIL mid_drain got=%0d want=0", exp_q.size()); end
    endtask

    task automatic test_watchdog();
        int stall;
        bit bad;
        push(2, 32'h2222_0001, 1'b0);
        push(3, 32'h3333_0001, 1'b1);
        expect_beat(32'h2222_0001, 1'b0);
`ifdef PKT_ARB_WATCHDOG_EN
        expect_beat(32'h3333_0001, 1'b1);
        stall = 0;
        for (int c = 0; c < 40; c++) begin
            @(negedge CLK);
            if (abort_o) break;
            if (busy_o && grant_o == 2'd2 && !req_valid_i[2]) stall++;
        end
        checks += 3;
        if (abort_o !== 1'b1) begin errors++; $display("FAIL wdog_abort got=%b want=1", abort_o); end
        if (stall !== 8) begin errors++; $display("FAIL wdog_stall got=%0d want=8", stall); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL wdog_idle got=%b want=0", busy_o); end
        @(negedge CLK);
        checks += 2;
        if (abort_o !== 1'b0) begin errors++; $display("FAIL wdog_pulse got=%b want=0", abort_o); end
        if (busy_o !== 1'b1 || grant_o !== 2'd3) begin errors++; $display("FAIL wdog_next got=%b/%0d want=1/3", busy_o, grant_o); end
`else
        bad = 1'b0;
        stall = 0;
        repeat (4) @(negedge CLK);
        for (int c = 0; c < 30; c++) begin
            @(negedge CLK);
            if (busy_o !== 1'b1 || grant_o !== 2'd2 || abort_o !== 1'b0) bad = 1'b1;
            stall++;
        end
        checks++;
        if (bad) begin errors++; $display("FAIL nowdog_hold got=busy%b/g%0d/abort%b want=1/2/0", busy_o, grant_o, abort_o); end
        push(2, 32'h2222_0002, 1'b1);
        expect_beat(32'h2222_0002, 1'b1);
        expect_beat(32'h3333_0001, 1'b1);
`endif
        repeat (10) @(negedge CLK);
        checks += 2;
        if (exp_q.size() !== 0) begin errors++; $display("FAIL wdog_drain got=%0d want=0", exp_q.size()); end
        if (busy_o !== 1'b0) begin errors++; $display("FAIL wdog_end_idle got=%b want=0", busy_o); end
    endtask

    initial begin
        test_reset();
        test_two_packets();
        test_rr_ptr();
        test_stall();
        test_round_robin();
        test_reset_mid_packet();
        test_watchdog();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/pkt_mem_arbiter.md
PKT_MEM_ARBITER -- requirements
Module: pkt_mem_arbiter

Interface
REQ-001 SHALL have parameter NUM_REQ, default 4: number of parser requesters, 2..8.
REQ-002 SHALL have parameter DATA_W, default 32: beat width in bits (BUS_WIDTH_B * BYTE_WIDTH).
REQ-003 SHALL have parameter WDOG_CYCLES, default 64: watchdog stall limit in cycles, 2..255.
REQ-004 SHALL have port CLK  input  1  sole clock; all state rising-edge.
REQ-005 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port req_valid_i  input  NUM_REQ  per-requester beat valid.
REQ-007 SHALL have port req_data_i  input  NUM_REQ*DATA_W  requester i beat data at bits [i*DATA_W +: DATA_W].
REQ-008 SHALL have port req_last_i  input  NUM_REQ  final beat of packet flag, qualified by req_valid_i.
REQ-009 SHALL have port req_ready_o  output  NUM_REQ  per-requester beat accept.
REQ-010 SHALL have port mem_out  output  DATA_W  registered write data to packet memory.
REQ-011 SHALL have port mem_w_valid  output  1  mem_out holds a valid beat.
REQ-012 SHALL have port w_ready  input  1  memory accepts beat when high together with mem_w_valid.
REQ-013 SHALL have port mem_w_last  output  1  registered copy of req_last_i for the beat in mem_out.
REQ-014 SHALL have port grant_o  output  clog2(NUM_REQ)  index of current owner, valid while busy_o.
REQ-015 SHALL have port busy_o  output  1  high in LOCK state.
REQ-016 SHALL have port abort_o  output  1  one-cycle pulse on watchdog abort.

Function
REQ-017 SHALL implement FSM with states IDLE and LOCK.
REQ-018 SHALL, in IDLE with any req_valid_i high, select the first valid requester scanning from rr_ptr upward modulo NUM_REQ, load grant_o, and enter LOCK next cycle; req_ready_o all low in IDLE (one-cycle arbitration latency).
REQ-019 SHALL, in LOCK, drive req_ready_o[grant_o] = !mem_w_valid || w_ready; all other bits 0.
REQ-020 SHALL, on req_valid_i[g] && req_ready_o[g], register req_data_i slice into mem_out, req_last_i[g] into mem_w_last, and set mem_w_valid.
REQ-021 SHALL clear mem_w_valid when mem_w_valid && w_ready and no new beat is loaded the same cycle; mem_out and mem_w_valid SHALL hold stable while mem_w_valid && !w_ready.
REQ-022 SHALL, when a beat with req_last_i=1 is accepted from the owner, return to IDLE next cycle and set rr_ptr = (grant_o+1) mod NUM_REQ; the pending output beat still drains via w_ready.
REQ-023 SHALL never interleave beats of different requesters; grant held for the full packet regardless of other requests.
REQ-024 SHALL, on a single-beat packet (valid and last on first accepted beat), spend exactly one cycle in LOCK.
REQ-025 SHALL ignore req_last_i and req_data_i of non-owners and while req_valid_i is low.
REQ-026 SHALL keep rr_ptr unchanged when IDLE sees no valid request.

Reset
REQ-027 SHALL on reset assert asynchronously: state IDLE, rr_ptr 0, grant_o 0, busy_o 0, req_ready_o 0, mem_out 0, mem_w_valid 0, mem_w_last 0, abort_o 0, watchdog counter 0.
REQ-028 SHALL on reset mid-packet discard the in-flight beat and packet; after release, arbitration restarts from requester 0.

Configuration
REQ-029 SHALL compile watchdog logic only when macro PKT_ARB_WATCHDOG_EN is defined.
REQ-030 SHALL, with PKT_ARB_WATCHDOG_EN, count consecutive LOCK cycles with req_valid_i[grant_o] low, clearing on any owner beat; on reaching WDOG_CYCLES, return to IDLE, advance rr_ptr past owner, pulse abort_o one cycle, leave mem_w_valid beat to drain.
REQ-031 SHALL, without PKT_ARB_WATCHDOG_EN, hold LOCK indefinitely until owner's last beat, tie abort_o to 0, and ignore WDOG_CYCLES.

Verification
REQ-032 SHALL verify: req 0 and 2 valid from reset, 3-beat packets, w_ready=1 -> grant 0 beats A0..A2 then grant 2 beats C0..C2, one idle arbitration cycle between, rr_ptr=3 after.
REQ-033 SHALL verify: w_ready low 5 cycles after first beat 0xDEADBEEF -> mem_out stays 0xDEADBEEF, mem_w_valid high, req_ready_o[owner]=0 throughout.
REQ-034 SHALL verify: all 4 requesters continuously valid, single-beat packets -> grants sequence 0,1,2,3,0, each LOCK exactly 1 cycle.
REQ-035 SHALL verify: reset asserted in LOCK mid-packet of req 1 (beat 2 of 4) -> all outputs 0 within same cycle, after release req 1 and 3 valid -> grant 1 first.
REQ-036 SHALL verify: with PKT_ARB_WATCHDOG_EN and WDOG_CYCLES=8, owner 2 drops valid after beat 1 -> abort_o pulses after 8 stall cycles, requester 3 granted next; without macro -> LOCK held, abort_o 0.
